// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_det_pkg
//  Purpose  : Shared types, constants and helper functions for the
//             parametrised serial pattern detector.
//  Revision : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    // Widest pattern the border helper can analyse.
    localparam int c_MAX_PAT_W = 32;

    // Pattern loaded at reset for the default 3-bit configuration.
    localparam logic [2:0] c_RST_PAT = 3'b110;

    // What a single clock edge does to the detector.
    typedef enum logic [1:0] {
        EV_HOLD = 2'd0,   // no valid bit, state holds
        EV_LOAD = 2'd1,   // new pattern latched, detection restarts
        EV_BIT  = 2'd2    // one valid serial bit consumed
    } step_e;

    // Width of the state output: enough bits for 0..pat_w-1.
    function automatic int st_width(input int pat_w);
        return (pat_w > 1) ? $clog2(pat_w) : 1;
    endfunction

    // Longest proper border of the pattern: the longest k < pat_w whose
    // top-k prefix equals its bottom-k suffix. Zero if none exists.
    function automatic int border_len(input logic [c_MAX_PAT_W-1:0] pat,
                                      input int                     pat_w);
        int                     res;
        logic [c_MAX_PAT_W-1:0] mask;
        res  = 0;
        mask = '0;
        for (int k = 1; k < c_MAX_PAT_W; k++) begin
            if (k < pat_w) begin
                mask = (c_MAX_PAT_W'(1) << k) - c_MAX_PAT_W'(1);
                if (((pat >> (pat_w - k)) & mask) == (pat & mask)) begin
                    res = k;
                end
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_detector_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detector_param_if
//  Purpose  : Bit-stream, control and result signals of the serial pattern
//             detector. master = stimulus side, slave = detector side.
//  Revision : 1.0 - initial release
// ============================================================================
interface seq_detector_param_if
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
);
    localparam int ST_W = st_width(PAT_W);

    logic             in_i;
    logic             in_valid_i;
    logic             pat_load_i;
    logic [PAT_W-1:0] pattern_i;
    logic             overlap_i;
    logic             clear_i;
    logic [ST_W-1:0]  q_o;
    logic             y_o;
    logic [CNT_W-1:0] match_cnt_o;

    modport master (
        output in_i, in_valid_i, pat_load_i, pattern_i, overlap_i, clear_i,
        input  q_o, y_o, match_cnt_o
    );

    modport slave (
        input  in_i, in_valid_i, pat_load_i, pattern_i, overlap_i, clear_i,
        output q_o, y_o, match_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/seq_prefix_match.sv
`default_nettype none
// ============================================================================
//  Module   : seq_prefix_match
//  Purpose  : Combinational finder of the longest suffix of the received
//             stream (stored history plus the incoming bit) that equals the
//             top bits of the pattern, limited by how many bits have been
//             received since the last restart.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_prefix_match #(
    parameter int PAT_W = 3,
    parameter int LEN_W = 2
) (
    input  wire logic [PAT_W-1:0] hist_i,   // older bits, LSB = most recent
    input  wire logic             bit_i,    // bit arriving on this edge
    input  wire logic [PAT_W-1:0] pat_i,    // pattern, MSB compared first
    input  wire logic [LEN_W-1:0] fill_i,   // bits since restart, saturated
    output logic      [LEN_W-1:0] len_o     // matched length 0..PAT_W
);
    // Newest bit in position 0; the oldest stored bit is always masked off
    // because no candidate is longer than PAT_W.
    logic [PAT_W:0] w_window;
    logic [LEN_W:0] w_avail;

    assign w_window = {hist_i, bit_i};
    assign w_avail  = {1'b0, fill_i} + (LEN_W + 1)'(1);

    // Try every length and keep the longest that matches the pattern head
    // without reaching back past the restart point.
    always_comb begin
        logic [PAT_W:0] w_mask;
        logic [PAT_W:0] w_head;
        len_o  = '0;
        w_mask = '0;
        w_head = '0;
        for (int k = 1; k <= PAT_W; k++) begin
            w_mask = {(PAT_W + 1){1'b1}} >> (PAT_W + 1 - k);
            w_head = {1'b0, pat_i} >> (PAT_W - k);
            if ((k <= int'(w_avail)) && (((w_head ^ w_window) & w_mask) == '0)) begin
                len_o = LEN_W'(k);
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detector_param
//  Purpose  : Run-time programmable serial pattern detector with overlapping
//             and non-overlapping modes, valid-qualified input and a
//             registered one-cycle match pulse.
//             Optional saturating match counter enabled by defining
//             SEQ_DET_MATCH_CNT_EN; otherwise match_cnt_o is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(c_RST_PAT),
    parameter int               CNT_W   = 8
) (
    input wire logic          clk,
    input wire logic          rst,
    seq_detector_param_if.slave bus
);
    localparam int               ST_W   = st_width(PAT_W);
    localparam int               LEN_W  = $clog2(PAT_W + 1);
    localparam logic [LEN_W-1:0] c_FULL = LEN_W'(PAT_W);

    logic [PAT_W-1:0] pat_q,   pat_d;
    logic [PAT_W-1:0] hist_q,  hist_d;
    logic [LEN_W-1:0] fill_q,  fill_d;
    logic [ST_W-1:0]  state_q, state_d;
    logic             y_q,     y_d;

    step_e            w_ev;
    logic [LEN_W-1:0] w_len;
    logic [ST_W-1:0]  w_border;
    logic             w_match;

    seq_prefix_match #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_prefix (
        .hist_i (hist_q),
        .bit_i  (bus.in_i),
        .pat_i  (pat_q),
        .fill_i (fill_q),
        .len_o  (w_len)
    );

    // Restart state after an overlapping match.
    assign w_border = ST_W'(border_len(c_MAX_PAT_W'(pat_q), PAT_W));
    assign w_match  = (w_ev == EV_BIT) && (w_len == c_FULL);

    // Classify the edge: a pattern load discards any coincident bit.
    always_comb begin
        w_ev = EV_HOLD;
        if (bus.pat_load_i) begin
            w_ev = EV_LOAD;
        end else if (bus.in_valid_i) begin
            w_ev = EV_BIT;
        end
    end

    // Next-state: shift history, advance prefix length, handle matches.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        y_d     = 1'b0;
        case (w_ev)
            EV_LOAD: begin
                pat_d   = bus.pattern_i;
                state_d = '0;
                hist_d  = '0;
                fill_d  = '0;
            end
            EV_BIT: begin
                hist_d = {hist_q[PAT_W-2:0], bus.in_i};
                if (fill_q != c_FULL) begin
                    fill_d = fill_q + LEN_W'(1);
                end
                if (w_match) begin
                    y_d = 1'b1;
                    if (bus.overlap_i) begin
                        state_d = w_border;
                    end else begin
                        // Forget the whole match so none of its bits recount.
                        state_d = '0;
                        hist_d  = '0;
                        fill_d  = '0;
                    end
                end else begin
                    state_d = w_len[ST_W-1:0];
                end
            end
            default: ;
        endcase
    end

    // State, pattern, history and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
            pat_q   <= RST_PAT;
            hist_q  <= '0;
            fill_q  <= '0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            y_q     <= y_d;
        end
    end

    assign bus.q_o = state_q;
    assign bus.y_o = y_q;

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating match counter; clear wins over a coincident match.
    always_ff @(posedge clk) begin
        if (rst || bus.clear_i) begin
            cnt_q <= '0;
        end else if (w_match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.match_cnt_o = cnt_q;
`else
    assign bus.match_cnt_o = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire
